// File: rtl/filt_pkg.sv
// ---------------------------------------------------------------------------
// filt_pkg -- shared helpers for the filter family.
//   ch_width    : channel index width, never less than 1 bit
//   depth_width : width of a log2 window selector that can hold 0..max_depth
//   acc_width   : accumulator width that holds a full window without overflow
//   shift_rtz   : arithmetic divide by 2**sh, rounding toward zero
// ---------------------------------------------------------------------------
package filt_pkg;

  localparam int RTZ_W = 64;

  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int depth_width(input int max_depth);
    return (max_depth > 0) ? $clog2(max_depth + 1) : 1;
  endfunction

  function automatic int acc_width(input int data_width, input int max_depth);
    return data_width + max_depth;
  endfunction

  // A plain >>> rounds toward minus infinity; shifting the magnitude and
  // restoring the sign gives truncation toward zero instead.
  function automatic logic signed [RTZ_W-1:0] shift_rtz(
    input logic signed [RTZ_W-1:0] a,
    input logic        [7:0]       sh
  );
    logic signed [RTZ_W-1:0] mag;
    if (a < 0) begin
      mag = -a;
      return -(mag >> sh);
    end
    return a >> sh;
  endfunction

endpackage

// File: rtl/filt_boxcar_mc_if.sv
// ---------------------------------------------------------------------------
// filt_boxcar_mc_if -- sample stream into and out of the boxcar filter.
//   in_valid/in_ch/in_data      : input sample, driven by the master
//   out_valid/out_ch/out_data/
//   out_primed                  : filtered result, driven by the slave
// Handshake: valid-only. in_valid qualifies in_ch/in_data in the cycle it is
// high; there is no ready, the filter takes one sample every cycle. out_valid
// is a one-cycle pulse qualifying out_ch/out_data/out_primed.
// ---------------------------------------------------------------------------
interface filt_boxcar_mc_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CH_W       = 2
);
  logic                         in_valid;
  logic        [CH_W-1:0]       in_ch;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         out_valid;
  logic        [CH_W-1:0]       out_ch;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         out_primed;

  modport master (
    output in_valid, in_ch, in_data,
    input  out_valid, out_ch, out_data, out_primed
  );

  modport slave (
    input  in_valid, in_ch, in_data,
    output out_valid, out_ch, out_data, out_primed
  );
endinterface

// File: rtl/ram_sdp_sync.sv
// ---------------------------------------------------------------------------
// ram_sdp_sync -- simple dual-port RAM, one write port, one synchronous read
// port. A read and write to the same address in one cycle returns the old
// contents; any forwarding is the caller's job. Contents are not reset.
//   clk     : clock
//   wr_en   : write strobe for wr_addr/wr_data
//   rd_addr : read address, data appears on rd_q after the next edge
// ---------------------------------------------------------------------------
module ram_sdp_sync #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 128,
  parameter int ADDR_W     = 7
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_q
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_q <= mem[rd_addr];
  end

endmodule

// File: rtl/filt_boxcar_mc.sv
// ---------------------------------------------------------------------------
// filt_boxcar_mc -- multi-channel moving average over a window of
// L = 2**depth_sel samples, channels time-multiplexed on one stream.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : flush all channel windows (RAM contents are left alone)
//   depth_sel : log2 window length, saturates at MAX_DEPTH; any change
//               flushes all channel windows
//   bus       : sample stream (slave side), see filt_boxcar_mc_if
// Two stages: S0 reads the sample leaving the window and bumps wptr/count,
// S1 updates the accumulator, writes the new sample and registers outputs.
// ---------------------------------------------------------------------------
module filt_boxcar_mc
  import filt_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_CH     = 4,
  parameter  int MAX_DEPTH  = 5,
  localparam int CH_W       = ch_width(NUM_CH),
  localparam int D_W        = depth_width(MAX_DEPTH),
  localparam int ACC_W      = acc_width(DATA_WIDTH, MAX_DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic [D_W-1:0] depth_sel,
  filt_boxcar_mc_if.slave bus
);

  localparam int                AW       = CH_W + MAX_DEPTH;
  localparam logic [D_W-1:0]    MAX_D    = D_W'(MAX_DEPTH);
  localparam logic [CH_W:0]     NUM_CH_V = (CH_W + 1)'(NUM_CH);
  localparam logic [MAX_DEPTH:0] ONE_CNT = (MAX_DEPTH + 1)'(1);

  // Per-channel window state.
  logic signed [ACC_W-1:0]     acc   [NUM_CH];
  logic        [MAX_DEPTH-1:0] wptr  [NUM_CH];
  logic        [MAX_DEPTH:0]   count [NUM_CH];

  logic [D_W-1:0] depth_q;
  logic [D_W-1:0] depth_eff;
  logic [MAX_DEPTH:0] win_len;
  logic flush;

  // S0 signals
  logic                 in_range;
  logic                 s0_take;
  logic [CH_W-1:0]      s0_ch;
  logic [MAX_DEPTH-1:0] wptr_cur;
  logic [MAX_DEPTH:0]   cnt_cur;
  logic [AW-1:0]        rd_addr;

  // S1 registers
  logic                         s1_valid;
  logic [CH_W-1:0]              s1_ch;
  logic signed [DATA_WIDTH-1:0] s1_data;
  logic [MAX_DEPTH-1:0]         s1_wptr;
  logic                         s1_full;
  logic                         s1_primed;
  logic                         s1_byp;
  logic signed [DATA_WIDTH-1:0] s1_byp_data;

  logic                         wr_en;
  logic [AW-1:0]                wr_addr;
  logic [DATA_WIDTH-1:0]        rd_q;
  logic signed [DATA_WIDTH-1:0] old_s;
  logic signed [ACC_W-1:0]      acc_new;
  logic signed [RTZ_W-1:0]      avg_w;
  logic                         unused_avg_hi;

  always_comb begin
    depth_eff = (depth_q > MAX_D) ? MAX_D : depth_q;
    win_len   = ONE_CNT << depth_eff;
    // A new window length invalidates every running sum, so it flushes.
    flush     = clear | (depth_sel != depth_q);

    in_range  = ({1'b0, bus.in_ch} < NUM_CH_V);
    s0_take   = bus.in_valid & in_range & ~flush;
    s0_ch     = in_range ? bus.in_ch : '0;
    wptr_cur  = wptr[s0_ch];
    cnt_cur   = count[s0_ch];
    // Oldest sample of the window; for L = 2**MAX_DEPTH this wraps onto the
    // slot about to be overwritten, which still holds it.
    rd_addr   = {s0_ch, wptr_cur - win_len[MAX_DEPTH-1:0]};

    wr_en     = s1_valid & ~flush & ~rst;
    wr_addr   = {s1_ch, s1_wptr};

    // Before the window fills the RAM slot is stale, so the leaving sample is 0.
    old_s     = '0;
    if (s1_full) begin
      old_s = s1_byp ? s1_byp_data : $signed(rd_q);
    end
    acc_new   = acc[s1_ch] + ACC_W'(s1_data) - ACC_W'(old_s);
    avg_w     = shift_rtz(RTZ_W'(acc_new), 8'(depth_eff));
    unused_avg_hi = ^avg_w[RTZ_W-1:DATA_WIDTH];
  end

  ram_sdp_sync #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (NUM_CH << MAX_DEPTH),
    .ADDR_W     (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (s1_data),
    .rd_addr (rd_addr),
    .rd_q    (rd_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q        <= depth_sel;
      s1_valid       <= 1'b0;
      s1_ch          <= '0;
      s1_data        <= '0;
      s1_wptr        <= '0;
      s1_full        <= 1'b0;
      s1_primed      <= 1'b0;
      s1_byp         <= 1'b0;
      s1_byp_data    <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_ch     <= '0;
      bus.out_data   <= '0;
      bus.out_primed <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i]   <= '0;
        wptr[i]  <= '0;
        count[i] <= '0;
      end
    end else if (flush) begin
      // Drops the S0 sample and the S1 sample in flight.
      depth_q       <= depth_sel;
      s1_valid      <= 1'b0;
      bus.out_valid <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i]   <= '0;
        wptr[i]  <= '0;
        count[i] <= '0;
      end
    end else begin
      if (s0_take) begin
        wptr[s0_ch]  <= wptr_cur + MAX_DEPTH'(1);
        count[s0_ch] <= (cnt_cur >= win_len) ? win_len : cnt_cur + ONE_CNT;
      end
      s1_valid    <= s0_take;
      s1_ch       <= s0_ch;
      s1_data     <= bus.in_data;
      s1_wptr     <= wptr_cur;
      s1_full     <= (cnt_cur >= win_len);
      s1_primed   <= (cnt_cur >= win_len - ONE_CNT);
      // The RAM returns pre-write data, so a same-cycle write to the slot
      // being read (same channel back to back with L = 1) is forwarded.
      s1_byp      <= wr_en && (rd_addr == wr_addr);
      s1_byp_data <= s1_data;

      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        acc[s1_ch]     <= acc_new;
        bus.out_ch     <= s1_ch;
        bus.out_data   <= avg_w[DATA_WIDTH-1:0];
        bus.out_primed <= s1_primed;
      end
    end
  end

endmodule
